// File: rtl/ps2_pkg.sv
// Shared types, scancode/keycode constants and direction helpers for the PS/2 arrow-key path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] KC_UP    = 8'd82;
  localparam logic [7:0] KC_DOWN  = 8'd81;
  localparam logic [7:0] KC_LEFT  = 8'd80;
  localparam logic [7:0] KC_RIGHT = 8'd79;
  localparam logic [7:0] KC_NONE  = 8'd0;

  function automatic dir_e dir_of_scan(logic [7:0] b);
    case (b)
      SC_UP:    return DIR_UP;
      SC_DOWN:  return DIR_DOWN;
      SC_LEFT:  return DIR_LEFT;
      SC_RIGHT: return DIR_RIGHT;
      default:  return DIR_NONE;
    endcase
  endfunction

  // Bit position in `held`: [3] up, [2] down, [1] left, [0] right.
  function automatic logic [3:0] dir_mask(dir_e d);
    case (d)
      DIR_UP:    return 4'b1000;
      DIR_DOWN:  return 4'b0100;
      DIR_LEFT:  return 4'b0010;
      DIR_RIGHT: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic dir_e top_held(logic [3:0] h);
    if (h[3])      return DIR_UP;
    else if (h[2]) return DIR_DOWN;
    else if (h[1]) return DIR_LEFT;
    else if (h[0]) return DIR_RIGHT;
    else           return DIR_NONE;
  endfunction

  function automatic logic [7:0] keycode_of(dir_e d);
    case (d)
      DIR_UP:    return KC_UP;
      DIR_DOWN:  return KC_DOWN;
      DIR_LEFT:  return KC_LEFT;
      DIR_RIGHT: return KC_RIGHT;
      default:   return KC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 pin synchronisation, falling-edge sampling, 11-bit frame check and mid-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             dat_s1_q, dat_s2_q;
  frame_state_e     state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample;

  // Sync flops reset to the idle-high line level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign sample = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    cnt_d     = (sample || state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
    rx_byte   = shift_q;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
    if (sample) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = ^{shift_q, dat_s2_q};
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (dat_s2_q && par_ok_q) rx_valid = 1'b1;
          else                      rx_err   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      rx_err  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard to arrow-key keycode: prefix decoding, held-key tracking and last-pressed arbitration.
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] keycode,
  output logic [3:0] held,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk      (Clk),
    .rst      (Reset),
    .ps2_clk  (PS2_CLK),
    .ps2_data (PS2_DATA),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  logic       ext_q, ext_d, brk_q, brk_d;
  logic [3:0] held_q, held_d;
  dir_e       last_q, last_d, dir;
  logic [3:0] mask;
  logic [7:0] keycode_q, keycode_d, scan_code_q, scan_code_d;
  logic       scan_valid_q, scan_valid_d, frame_err_q, frame_err_d;

  assign dir  = dir_of_scan(rx_byte);
  assign mask = dir_mask(dir);

  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    held_d       = held_q;
    last_d       = last_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (rx_err) begin
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end else if (rx_valid) begin
      scan_valid_d = 1'b1;
      scan_code_d  = rx_byte;
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q && dir != DIR_NONE) begin
          if (!brk_q) begin
            held_d = held_q | mask;
            last_d = dir;
          end else if ((held_q & mask) != 4'b0000) begin
            // Releasing the active key hands control to the best key still down.
            held_d = held_q & ~mask;
            if (last_q == dir) last_d = top_held(held_d);
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    keycode_d = keycode_of(last_d);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_q       <= '0;
      last_q       <= DIR_NONE;
      keycode_q    <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      held_q       <= held_d;
      last_q       <= last_d;
      keycode_q    <= keycode_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign keycode    = keycode_q;
  assign held       = held_q;
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: bit-level PS/2 frames against a set-based arrow-key model.
module tb_ps2_keycode;

  localparam int HALF = 20;

  logic       Clk = 1'b0;
  logic       Reset, PS2_CLK, PS2_DATA;
  logic [7:0] keycode, scan_code;
  logic [3:0] held;
  logic       scan_valid, frame_err;

  ps2_keycode #(.TIMEOUT_CYCLES(5000)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .keycode    (keycode),
    .held       (held),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err)
  );

  always #10 Clk = ~Clk;

  int tests = 0, fails = 0;

  int         valid_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  logic [7:0] mon_code = '0, kc_at_valid = '0;

  always @(negedge Clk) begin
    if (scan_valid) begin
      valid_cnt++;
      mon_code    = scan_code;
      kc_at_valid = keycode;
    end
    if (frame_err) err_cnt++;
    if (scan_valid && frame_err) overlap_cnt++;
  end

  // Reference model: the set of held arrows (index 3 up .. 0 right) and the most recent press.
  bit         mh [4];
  int         m_last = -1;
  bit         m_ext = 0, m_brk = 0;
  int         exp_valid = 0, exp_err = 0;
  logic [7:0] exp_code = '0;

  function automatic int scan_idx(logic [7:0] b);
    case (b)
      8'h75: return 3;
      8'h72: return 2;
      8'h6B: return 1;
      8'h74: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] exp_kc();
    case (m_last)
      3: return 8'd82;
      2: return 8'd81;
      1: return 8'd80;
      0: return 8'd79;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [3:0] exp_held();
    return {mh[3], mh[2], mh[1], mh[0]};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int idx;
    exp_valid++;
    exp_code = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      idx = scan_idx(b);
      if (m_ext && idx >= 0) begin
        if (!m_brk) begin
          mh[idx] = 1;
          m_last  = idx;
        end else if (mh[idx]) begin
          mh[idx] = 0;
          if (m_last == idx) begin
            m_last = -1;
            for (int i = 3; i >= 0; i--) if (mh[i] && m_last < 0) m_last = i;
          end
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_err();
    exp_err++;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mh[i] = 0;
    m_last   = -1;
    m_ext    = 0;
    m_brk    = 0;
    exp_code = '0;
  endtask

  task automatic ps2_bit(input logic v);
    PS2_DATA = v;
    repeat (HALF) @(posedge Clk);
    #2 PS2_CLK = 1'b0;
    repeat (HALF) @(posedge Clk);
    #2 PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(bad_par ? ^b : ~^b);
    ps2_bit(bad_stop ? 1'b0 : 1'b1);
    PS2_DATA = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    if (bad_par || bad_stop) model_err();
    else model_byte(b);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(i[0]);
    PS2_DATA = 1'b1;
  endtask

  task automatic test_reset();
    if (keycode !== 8'd0) begin fails++; $display("FAIL reset_keycode got %0d want 0", keycode); end
    tests++;
    if (held !== 4'b0000) begin fails++; $display("FAIL reset_held got %b want 0000", held); end
    tests++;
    if (scan_code !== 8'h00) begin fails++; $display("FAIL reset_scan_code got %h want 00", scan_code); end
    tests++;
    if (scan_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++; $display("FAIL reset_pulses got valid=%b err=%b want 0 0", scan_valid, frame_err);
    end
    tests++;
  endtask

  task automatic test_idle();
    repeat (10000) @(posedge Clk);
    #1;
    if (keycode !== 8'd0 || held !== 4'b0000) begin
      fails++; $display("FAIL idle_outputs got kc=%0d held=%b want 0 0000", keycode, held);
    end
    tests++;
    if (valid_cnt !== 0 || err_cnt !== 0) begin
      fails++; $display("FAIL idle_pulses got valid=%0d err=%0d want 0 0", valid_cnt, err_cnt);
    end
    tests++;
  endtask

  task automatic test_up_press_release();
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    if (valid_cnt !== exp_valid) begin fails++; $display("FAIL up_valid_cnt got %0d want %0d", valid_cnt, exp_valid); end
    tests++;
    if (mon_code !== 8'h75) begin fails++; $display("FAIL up_scan_code got %h want 75", mon_code); end
    tests++;
    if (kc_at_valid !== 8'd82) begin fails++; $display("FAIL up_kc_with_valid got %0d want 82", kc_at_valid); end
    tests++;
    if (keycode !== 8'd82 || held !== 4'b1000) begin
      fails++; $display("FAIL up_make got kc=%0d held=%b want 82 1000", keycode, held);
    end
    tests++;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    if (keycode !== 8'd0 || held !== 4'b0000) begin
      fails++; $display("FAIL up_break got kc=%0d held=%b want 0 0000", keycode, held);
    end
    tests++;
  endtask

  task automatic test_arbitration();
    logic [23:0] seq  [7] = '{24'hE075_00, 24'hE06B_00, 24'hE0F06B, 24'hE074_00,
                              24'hE0F075, 24'hE0F072, 24'hE0F074};
    int          len  [7] = '{2, 2, 3, 2, 3, 3, 3};
    logic [7:0]  kc   [7] = '{8'd82, 8'd80, 8'd82, 8'd79, 8'd79, 8'd79, 8'd0};
    logic [3:0]  hl   [7] = '{4'b1000, 4'b1010, 4'b1000, 4'b1001, 4'b0001, 4'b0001, 4'b0000};
    logic [23:0] s;
    for (int k = 0; k < 7; k++) begin
      s = seq[k];
      for (int j = 0; j < len[k]; j++) send_frame(s[23-8*j -: 8], 0, 0);
      if (keycode !== kc[k] || held !== hl[k]) begin
        fails++; $display("FAIL arb_step%0d got kc=%0d held=%b want %0d %b", k, keycode, held, kc[k], hl[k]);
      end
      tests++;
      if (keycode !== exp_kc() || held !== exp_held()) begin
        fails++; $display("FAIL arb_model%0d got kc=%0d held=%b want %0d %b", k, keycode, held, exp_kc(), exp_held());
      end
      tests++;
    end
  endtask

  task automatic test_frame_errors();
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 1, 0);
    if (err_cnt !== exp_err || valid_cnt !== exp_valid) begin
      fails++; $display("FAIL parity_err got err=%0d valid=%0d want %0d %0d", err_cnt, valid_cnt, exp_err, exp_valid);
    end
    tests++;
    if (keycode !== 8'd0) begin fails++; $display("FAIL parity_kc got %0d want 0", keycode); end
    tests++;
    send_frame(8'h75, 0, 0);
    if (keycode !== 8'd0 || held !== 4'b0000) begin
      fails++; $display("FAIL parity_ext_cleared got kc=%0d held=%b want 0 0000", keycode, held);
    end
    tests++;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    if (keycode !== 8'd79 || held !== 4'b0001) begin
      fails++; $display("FAIL after_err_decode got kc=%0d held=%b want 79 0001", keycode, held);
    end
    tests++;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 1);
    if (err_cnt !== exp_err || keycode !== 8'd79) begin
      fails++; $display("FAIL stop_err got err=%0d kc=%0d want %0d 79", err_cnt, keycode, exp_err);
    end
    tests++;
    if (scan_code !== exp_code) begin fails++; $display("FAIL stop_err_code got %h want %h", scan_code, exp_code); end
    tests++;
  endtask

  task automatic test_timeout();
    int v0;
    send_frame(8'hE0, 0, 0);
    v0 = valid_cnt;
    send_partial(4);
    repeat (6000) @(posedge Clk);
    #1;
    model_err();
    if (err_cnt !== exp_err || valid_cnt !== v0) begin
      fails++; $display("FAIL timeout_err got err=%0d valid=%0d want %0d %0d", err_cnt, valid_cnt, exp_err, v0);
    end
    tests++;
    send_frame(8'h72, 0, 0);
    if (keycode !== exp_kc() || held !== exp_held()) begin
      fails++; $display("FAIL timeout_ext_cleared got kc=%0d held=%b want %0d %b", keycode, held, exp_kc(), exp_held());
    end
    tests++;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h72, 0, 0);
    if (keycode !== 8'd81 || valid_cnt !== exp_valid) begin
      fails++; $display("FAIL timeout_recover got kc=%0d valid=%0d want 81 %0d", keycode, valid_cnt, exp_valid);
    end
    tests++;
  endtask

  task automatic test_random();
    logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] b;
    int         r;
    bit         bad, bp;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hE0;
      else if (r < 3) b = 8'hF0;
      else if (r < 7) b = arrows[r - 3];
      else            b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      bp  = $urandom_range(0, 1) == 1;
      send_frame(b, bad && bp, bad && !bp);
      if (keycode !== exp_kc() || held !== exp_held()) begin
        fails++; $display("FAIL rand%0d byte %h got kc=%0d held=%b want %0d %b", n, b, keycode, held, exp_kc(), exp_held());
      end
      tests++;
      if (valid_cnt !== exp_valid || err_cnt !== exp_err || scan_code !== exp_code) begin
        fails++; $display("FAIL rand%0d_pulses got v=%0d e=%0d code=%h want %0d %0d %h",
                          n, valid_cnt, err_cnt, scan_code, exp_valid, exp_err, exp_code);
      end
      tests++;
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_partial(3);
    #7 Reset = 1'b1;
    #1;
    model_reset();
    if (keycode !== 8'd0 || held !== 4'b0000 || scan_code !== 8'h00) begin
      fails++; $display("FAIL midreset_outputs got kc=%0d held=%b code=%h want 0 0000 00", keycode, held, scan_code);
    end
    tests++;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    if (err_cnt !== exp_err || valid_cnt !== exp_valid) begin
      fails++; $display("FAIL midreset_no_pulse got err=%0d valid=%0d want %0d %0d", err_cnt, valid_cnt, exp_err, exp_valid);
    end
    tests++;
    send_frame(8'h75, 0, 0);
    if (valid_cnt !== exp_valid || scan_code !== 8'h75) begin
      fails++; $display("FAIL midreset_plain got valid=%0d code=%h want %0d 75", valid_cnt, scan_code, exp_valid);
    end
    tests++;
    if (keycode !== 8'd0 || held !== 4'b0000) begin
      fails++; $display("FAIL midreset_kc got kc=%0d held=%b want 0 0000", keycode, held);
    end
    tests++;
  endtask

  task automatic test_no_overlap();
    if (overlap_cnt !== 0) begin fails++; $display("FAIL pulse_overlap got %0d want 0", overlap_cnt); end
    tests++;
  endtask

  initial begin
    Reset    = 1'b1;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    model_reset();
    repeat (5) @(posedge Clk);
    #2 Reset = 1'b0;
    @(posedge Clk);
    #1;
    test_reset();
    test_idle();
    test_up_press_release();
    test_arbitration();
    test_frame_errors();
    test_timeout();
    test_random();
    test_reset_midframe();
    test_no_overlap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
